// File: rtl/riscv_top.sv
// Unsigned WIDTH-bit adder built as a two-level carry-lookahead tree.
// The output is purely combinational. clock and reset exist only for interface compatibility.
module riscv_top #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  localparam int NG = WIDTH / 4;

  if (WIDTH <= 0 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("riscv_top: WIDTH must be a positive multiple of 4");
  end

  logic [WIDTH-1:0] g;   // per-bit generate
  logic [WIDTH-1:0] p;   // per-bit propagate
  logic [WIDTH-1:0] c;   // carry into each bit
  logic [NG-1:0]    gg;  // group generate
  logic [NG-1:0]    gp;  // group propagate
  logic [NG-1:0]    gc;  // group carry-in

  assign g = a & b;
  assign p = a ^ b;

  // Level 1: each 4-bit group derives its internal carries from its own carry-in only.
  for (genvar j = 0; j < NG; j++) begin : g_group
    localparam int B = 4 * j;

    assign c[B]   = gc[j];
    assign c[B+1] = g[B]   | (p[B]   & gc[j]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B])
                  | (p[B+1] & p[B]   & gc[j]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1])
                  | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & gc[j]);

    assign gg[j] = g[B+3] | (p[B+3] & g[B+2])
                 | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[j] = &p[B+3:B];
  end

  // Level 2: each group carry-in is a flat sum of products over the lower groups.
  // Bit 0 has no carry-in, so these products never depend on another group carry.
  always_comb begin
    logic term;
    // NOTE: always_comb uses blocking '=' and assigns every output before reading it,
    // so no latch is inferred. The loops unroll into parallel AND/OR terms, not a ripple chain.
    gc   = '0;
    term = 1'b0;
    for (int j = 1; j < NG; j++) begin
      for (int k = 0; k < j; k++) begin
        term = gg[k];
        for (int m = k + 1; m < j; m++) begin
          term = term & gp[m];
        end
        gc[j] = gc[j] | term;
      end
    end
  end

  assign sum = p ^ c;

  // The carry-out is intentionally discarded. clock and reset drive no logic.
  logic unused_sink;
  assign unused_sink = clock ^ reset ^ gg[NG-1] ^ gp[NG-1];

endmodule

// File: tb/tb_riscv_top.sv
// Self-checking bench for riscv_top: directed carry/wrap vectors,
// reset/clock independence, and a random sweep against a reference sum.
module tb_riscv_top;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] sum;

  int total = 0;
  int bad   = 0;

  riscv_top #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .a     (a),
    .b     (b),
    .sum   (sum)
  );

  always #5 if (clk_en) clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (a=%h b=%h)", tag, got, exp, a, b);
    end
  endtask

  task automatic apply(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp);
    a = av;
    b = bv;
    #1;
    check(tag, sum, exp);
  endtask

  typedef struct {
    string       tag;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[] = '{
    '{"zero",        32'h0000_0000, 32'h0000_0000, 32'h0000_0000},
    '{"wrap",        32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
    '{"cross16",     32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000},
    '{"cross28",     32'h0FFF_FFFF, 32'h0000_0001, 32'h1000_0000},
    '{"sign_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000},
    '{"min_min",     32'h8000_0000, 32'h8000_0000, 32'h0000_0000},
    '{"ones_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{"grp_gen",     32'h0000_000F, 32'h0000_000F, 32'h0000_001E},
    '{"alt_bits",    32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF},
    '{"alt_carry",   32'hAAAA_AAAA, 32'h5555_5556, 32'h0000_0000},
    '{"mid_chain",   32'h00FF_F000, 32'h0000_1000, 32'h0100_0000},
    '{"plain",       32'h1234_5678, 32'h1111_1111, 32'h2345_6789}
  };

  initial begin
    // Basic add with the clock idle: the result must appear within one time unit.
    apply("basic", 32'd2, 32'd3, 32'd5);
    if (bad != 0) begin
      $display("FAIL basic_fatal: combinational sum not ready without a clock");
      $fatal(1, "basic add failed");
    end

    foreach (vecs[i]) apply(vecs[i].tag, vecs[i].av, vecs[i].bv, vecs[i].exp);

    // Change both operands in the same timestep. No earlier value may remain in the result.
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; #1;
    a = 32'h0000_0001; b = 32'h0000_0002; #1;
    check("simul_change", sum, 32'h0000_0003);

    // The clock and reset must have no effect on the output.
    a = 32'h1234_5678;
    b = 32'h1111_1111;
    reset  = 1'b1;
    clk_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("rst_hi", sum, 32'h2345_6789);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("rst_lo", sum, 32'h2345_6789);
    end
    // Assert reset in the middle of an operand change.
    @(posedge clock);
    #1 reset = 1'b1; a = 32'hDEAD_BEEF; b = 32'h2152_4111;
    @(negedge clock);
    check("rst_mid", sum, 32'h0000_0000);
    reset  = 1'b0;
    clk_en = 1'b0;
    #1;

    // Random sweep. The first pairs hit the all-ones and all-zeros corners.
    for (int i = 0; i < 10000; i++) begin
      logic [32:0] full;
      case (i)
        0:       begin a = 32'h0;          b = 32'h0;          end
        1:       begin a = 32'hFFFF_FFFF;  b = 32'h0;          end
        2:       begin a = 32'h0;          b = 32'hFFFF_FFFF;  end
        3:       begin a = 32'hFFFF_FFFF;  b = 32'hFFFF_FFFF;  end
        default: begin a = $urandom;       b = $urandom;       end
      endcase
      full = {1'b0, a} + {1'b0, b};
      #1;
      check("random", sum, full[31:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_top.md
RISCV_TOP -- requirements
Module: riscv_top

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clock and reset as in the rest of the codebase.
REQ-002 Parameter WIDTH, default 32, operand and result width; SHALL be a positive multiple of 4.
REQ-003 Port: clock  input  1  single clock; no functional effect on sum.
REQ-004 Port: reset  input  1  synchronous, active-high; no functional effect on sum.
REQ-005 Port: a  input  WIDTH  first unsigned addend.
REQ-006 Port: b  input  WIDTH  second unsigned addend.
REQ-007 Port: sum  output  WIDTH  (a + b) mod 2^WIDTH.
REQ-008 The block SHALL have no other ports, so a wildcard (.*) instantiation binds exactly these five.

Function
REQ-009 sum SHALL be purely combinational from a and b, with zero clock latency, valid within the same delta/timestep as an input change and with no clock edge required.
REQ-010 sum SHALL equal the low WIDTH bits of a + b; carry-out SHALL be discarded, and the wrap-around is silent.
REQ-011 Operands SHALL be treated as unsigned; two's-complement signed addition gives identical bits, and signed overflow SHALL NOT be flagged.
REQ-012 The adder SHALL be built structurally as a two-level carry-lookahead adder, not with a behavioural "+" operator.
- Level 1: per-bit generate g[i] = a[i] & b[i] and propagate p[i] = a[i] ^ b[i].
- Level 1: 4-bit CLA groups produce internal carries and a group generate G and group propagate P.
- Level 2: a lookahead unit over the WIDTH/4 groups produces the group carry-ins.
- Carry-in to bit 0 is constant 0.
REQ-013 Sum bits SHALL be s[i] = p[i] ^ c[i], with c[i] being the carry into bit i.
REQ-014 Neither the group carry-in logic nor the sum logic SHALL ripple across group boundaries.
REQ-015 The block SHALL contain no latches, and its combinational paths SHALL not depend on clock or reset.
REQ-016 Simultaneous changes on a and b SHALL settle to the correct sum with no stale state.
REQ-017 X or Z on any input bit SHALL be allowed to propagate X to the affected sum bits; no masking is required.

Reset
REQ-018 The block holds no state, so reset SHALL NOT change sum.
REQ-019 Asserting reset at any time, including mid-operation, SHALL leave sum = (a + b) mod 2^WIDTH.
REQ-020 reset SHALL be sampled only on rising clock edges if any future state is added; any such state SHALL clear synchronously and SHALL NOT affect sum.

Verification
REQ-021 Basic add, no clock toggled: a=2, b=3, wait 1 time unit -> sum=5; otherwise $fatal.
REQ-022 Full-width wrap: a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000.
REQ-023 Cross-group carry chain: a=0x0000FFFF, b=0x00000001 -> sum=0x00010000; a=0x0FFFFFFF, b=0x00000001 -> sum=0x10000000.
REQ-024 Sign boundary: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000; a=0x80000000, b=0x80000000 -> sum=0x00000000.
REQ-025 Reset/clock independence: toggle clock for 10 cycles with reset=1 and then reset=0, with a=0x12345678, b=0x11111111 -> sum stays 0x23456789 throughout.
REQ-026 Random: at least 10,000 random a/b pairs -> sum equals the reference model (a + b) & 0xFFFFFFFF every time, including the all-ones and all-zeros corners.
